// File: rtl/riscv_pkg.sv
// Shared store-path definitions: funct3 encodings, store FSM states and
// the byte-lane size mask used by the store lane packer.
package riscv_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } st_state_t;

  // An all-zero mask marks an illegal funct3.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   size_mask = 4'b0001;
      F3_SH:   size_mask = 4'b0011;
      F3_SW:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/st_lane_gen.sv
// Combinational lane generator: narrows rs2 to the store size and shifts
// mask and data across an 8-byte window spanning two memory words.
module st_lane_gen
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  lane_mask,
  output logic [63:0] lane_data,
  output logic        illegal
);

  logic [3:0]  m;
  logic [31:0] narrow;

  always_comb begin
    m         = size_mask(funct3);
    illegal   = (m == 4'b0000);
    narrow    = data & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    lane_mask = {4'b0000, m} << off;
    lane_data = {32'h0000_0000, narrow} << {off, 3'b000};
  end

endmodule

// File: rtl/store_lane_packer.sv
// Store lane packer: turns an EX-stage store into one or two word-aligned
// memory write beats with byte enables, using a req/gnt handshake.
module store_lane_packer
  import riscv_pkg::*;
#(
  parameter int ALLOW_MISALIGNED = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  output logic        st_done,
  output logic        st_err
);

  st_state_t   state, next_state;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic        illegal;
  logic        accept;
  logic        split;
  logic        reject;
  logic        granted;
  logic        split_q;
  logic [3:0]  hi_be;
  logic [31:0] hi_wdata;

  st_lane_gen u_lane_gen (
    .funct3    (st_funct3),
    .off       (st_addr[1:0]),
    .data      (st_data),
    .lane_mask (lane_mask),
    .lane_data (lane_data),
    .illegal   (illegal)
  );

  assign st_ready = (state == IDLE) && !rst;
  assign accept   = st_valid && st_ready;
  assign split    = |lane_mask[7:4];
  assign reject   = illegal || (split && (ALLOW_MISALIGNED == 0));
  assign granted  = mem_req && mem_gnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept)  next_state = reject ? RESP : BEAT0;
      BEAT0: if (granted) next_state = split_q ? BEAT1 : RESP;
      BEAT1: if (granted) next_state = RESP;
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs are registered so they stay stable while waiting for gnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      split_q   <= 1'b0;
      hi_be     <= 4'h0;
      hi_wdata  <= 32'h0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              st_err <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_addr  <= {st_addr[31:2], 2'b00};
              mem_be    <= lane_mask[3:0];
              mem_wdata <= lane_data[31:0];
              hi_be     <= lane_mask[7:4];
              hi_wdata  <= lane_data[63:32];
              split_q   <= split;
            end
          end
        end
        BEAT0: begin
          if (granted) begin
            if (split_q) begin
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= hi_be;
              mem_wdata <= hi_wdata;
            end else begin
              mem_req   <= 1'b0;
              mem_be    <= 4'h0;
              mem_wdata <= 32'h0;
              st_done   <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (granted) begin
            mem_req   <= 1'b0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            st_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed self-checking bench for store_lane_packer, with a second instance
// built with ALLOW_MISALIGNED=0 to exercise the reject path.
module tb_store_lane_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, na_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr, st_data;
  logic        mem_gnt;

  logic        st_ready, mem_req, st_done, st_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        na_ready, na_req, na_done, na_err;
  logic [31:0] na_addr, na_wdata;
  logic [3:0]  na_be;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  store_lane_packer #(.ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .st_done(st_done), .st_err(st_err)
  );

  store_lane_packer #(.ALLOW_MISALIGNED(0)) dut_na (
    .clk(clk), .rst(rst), .st_valid(na_valid), .st_ready(na_ready),
    .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .mem_req(na_req), .mem_addr(na_addr), .mem_wdata(na_wdata),
    .mem_be(na_be), .mem_gnt(mem_gnt), .st_done(na_done), .st_err(na_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single accept edge; returns in cycle 1.
  task automatic applyStimulus(input bit use_na, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data);
    st_funct3 = f3;
    st_addr   = addr;
    st_data   = data;
    if (use_na) na_valid = 1'b1;
    else        st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
    na_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; na_valid = 1'b0; mem_gnt = 1'b1;
    st_funct3 = 3'b000; st_addr = 32'h0; st_data = 32'h0;
    tick(); tick();
    checkOutput("rst_ready", {31'b0, st_ready}, 32'h0);
    checkOutput("rst_req",   {31'b0, mem_req},  32'h0);
    checkOutput("rst_addr",  mem_addr,          32'h0);
    checkOutput("rst_done",  {30'b0, st_done, st_err}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("idle_ready", {31'b0, st_ready}, 32'h1);
    tick();

    // SB off=3, immediate grant
    applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'hDEAD_BEEF);
    checkOutput("sb3_req",   {31'b0, mem_req}, 32'h1);
    checkOutput("sb3_addr",  mem_addr,         32'h0000_1000);
    checkOutput("sb3_be",    {28'b0, mem_be},  32'h8);
    checkOutput("sb3_wdata", mem_wdata,        32'hEF00_0000);
    checkOutput("sb3_busy",  {31'b0, st_ready}, 32'h0);
    tick();
    checkOutput("sb3_done",  {31'b0, st_done}, 32'h1);
    checkOutput("sb3_req2",  {31'b0, mem_req}, 32'h0);
    tick();
    checkOutput("sb3_done_end", {31'b0, st_done}, 32'h0);
    checkOutput("sb3_ready",    {31'b0, st_ready}, 32'h1);

    // SB off=0: only the low byte of rs2 reaches the bus
    applyStimulus(1'b0, 3'b000, 32'h0000_4000, 32'hDEAD_BEEF);
    checkOutput("sb0_be",    {28'b0, mem_be}, 32'h1);
    checkOutput("sb0_wdata", mem_wdata,       32'h0000_00EF);
    tick(); tick();

    // SW off=1 splits into two beats
    applyStimulus(1'b0, 3'b010, 32'h0000_2001, 32'h1122_3344);
    checkOutput("sw1_b0_addr",  mem_addr,        32'h0000_2000);
    checkOutput("sw1_b0_be",    {28'b0, mem_be}, 32'hE);
    checkOutput("sw1_b0_wdata", mem_wdata,       32'h2233_4400);
    tick();
    checkOutput("sw1_b1_req",   {31'b0, mem_req}, 32'h1);
    checkOutput("sw1_b1_addr",  mem_addr,        32'h0000_2004);
    checkOutput("sw1_b1_be",    {28'b0, mem_be}, 32'h1);
    checkOutput("sw1_b1_wdata", mem_wdata,       32'h0000_0011);
    checkOutput("sw1_b1_done",  {31'b0, st_done}, 32'h0);
    tick();
    checkOutput("sw1_done",     {31'b0, st_done}, 32'h1);
    checkOutput("sw1_req_end",  {31'b0, mem_req}, 32'h0);
    tick();
    checkOutput("sw1_done_once", {31'b0, st_done}, 32'h0);

    // SH off=3 splits; upper half of rs2 must be dropped
    applyStimulus(1'b0, 3'b001, 32'h0000_5003, 32'hCAFE_BABE);
    checkOutput("sh3_b0_be",    {28'b0, mem_be}, 32'h8);
    checkOutput("sh3_b0_wdata", mem_wdata,       32'hBE00_0000);
    tick();
    checkOutput("sh3_b1_addr",  mem_addr,        32'h0000_5004);
    checkOutput("sh3_b1_be",    {28'b0, mem_be}, 32'h1);
    checkOutput("sh3_b1_wdata", mem_wdata,       32'h0000_00BA);
    tick(); tick();

    // SH off=2 with grant withheld; a new request during the wait is ignored
    mem_gnt = 1'b0;
    applyStimulus(1'b0, 3'b001, 32'h0000_0002, 32'h0000_ABCD);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("shw_req%0d", i),   {31'b0, mem_req}, 32'h1);
      checkOutput($sformatf("shw_addr%0d", i),  mem_addr,        32'h0000_0000);
      checkOutput($sformatf("shw_be%0d", i),    {28'b0, mem_be}, 32'hC);
      checkOutput($sformatf("shw_wdata%0d", i), mem_wdata,       32'hABCD_0000);
      checkOutput($sformatf("shw_done%0d", i),  {31'b0, st_done}, 32'h0);
      if (i == 1) begin
        st_funct3 = 3'b010; st_addr = 32'h0000_0700; st_data = 32'h7777_7777;
        st_valid  = 1'b1;
      end
      if (i == 2) st_valid = 1'b0;
      if (i == 3) mem_gnt = 1'b1;
      tick();
    end
    checkOutput("shw_done",   {31'b0, st_done}, 32'h1);
    tick();
    checkOutput("shw_no_2nd", {31'b0, mem_req}, 32'h0);
    checkOutput("shw_ready",  {31'b0, st_ready}, 32'h1);

    // Illegal funct3
    applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'h1234_5678);
    checkOutput("ill_req",  {31'b0, mem_req}, 32'h0);
    checkOutput("ill_err",  {31'b0, st_err},  32'h1);
    checkOutput("ill_done", {31'b0, st_done}, 32'h0);
    tick();
    checkOutput("ill_err_end", {31'b0, st_err},  32'h0);
    checkOutput("ill_ready",   {31'b0, st_ready}, 32'h1);

    // Misaligned SW rejected when splitting is disabled
    applyStimulus(1'b1, 3'b010, 32'h0000_3002, 32'h5566_7788);
    checkOutput("na_req",  {31'b0, na_req}, 32'h0);
    checkOutput("na_err",  {31'b0, na_err}, 32'h1);
    tick();
    checkOutput("na_ready", {31'b0, na_ready}, 32'h1);
    applyStimulus(1'b1, 3'b010, 32'h0000_3000, 32'h5566_7788);
    checkOutput("na_al_req",   {31'b0, na_req}, 32'h1);
    checkOutput("na_al_be",    {28'b0, na_be},  32'hF);
    checkOutput("na_al_wdata", na_wdata,        32'h5566_7788);
    tick(); tick();

    // Address wrap in beat1, then reset abandons the store
    applyStimulus(1'b0, 3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD);
    checkOutput("wrap_b0_addr",  mem_addr,        32'hFFFF_FFFC);
    checkOutput("wrap_b0_be",    {28'b0, mem_be}, 32'hC);
    checkOutput("wrap_b0_wdata", mem_wdata,       32'hCCDD_0000);
    tick();
    checkOutput("wrap_b1_addr",  mem_addr,        32'h0000_0000);
    checkOutput("wrap_b1_be",    {28'b0, mem_be}, 32'h3);
    checkOutput("wrap_b1_wdata", mem_wdata,       32'h0000_AABB);
    rst = 1'b1;
    tick();
    checkOutput("wrap_rst_req",   {31'b0, mem_req}, 32'h0);
    checkOutput("wrap_rst_done",  {31'b0, st_done}, 32'h0);
    checkOutput("wrap_rst_be",    {28'b0, mem_be},  32'h0);
    checkOutput("wrap_rst_ready", {31'b0, st_ready}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("wrap_ready", {31'b0, st_ready}, 32'h1);
    tick();
    checkOutput("wrap_no_done", {31'b0, st_done}, 32'h0);
    checkOutput("wrap_no_req",  {31'b0, mem_req}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/store_lane_packer.md
Name: store_lane_packer

Overview:
- Store-side counterpart of the load/immediate sign-extension path in the RISC-V core.
- Takes a 32-bit rs2 value plus address and funct3 (SB/SH/SW) from the EX stage.
- Narrows and shifts the value into byte lanes of a word-aligned data-memory write port, with byte enables.
- Splits misaligned SH/SW into two sequential bus beats via a req/gnt handshake.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split misaligned stores into two beats; 0 = flag an error and issue no bus write.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- st_valid  in  1  store request valid
- st_ready  out  1  block can accept a request (combinational: state==IDLE && !rst)
- st_funct3  in  3  000 SB, 001 SH, 010 SW; any other value is illegal
- st_addr  in  32  byte address
- st_data  in  32  rs2 value; only the low 8/16/32 bits are used
- mem_req  out  1  write request valid
- mem_addr  out  32  word-aligned address, bits [1:0] always 00
- mem_wdata  out  32  lane-shifted write data; disabled lanes are driven 0
- mem_be  out  4  byte enables
- mem_gnt  in  1  memory accepts the beat this cycle when mem_req && mem_gnt
- st_done  out  1  one-cycle pulse: store fully written
- st_err  out  1  one-cycle pulse: illegal funct3, or misaligned with ALLOW_MISALIGNED=0

Behaviour:
- Reset: clk and rst are the single clock and synchronous active-high reset. On any edge with rst=1, state goes to IDLE and mem_req, mem_addr, mem_wdata, mem_be, st_done and st_err all go to 0. st_ready is 0 while rst=1. Reset mid-beat abandons the store: no further beat, no st_done.
- Accept: on st_valid && st_ready, latch the request. Compute:
  - off = addr[1:0]
  - size mask m = 0001 (SB), 0011 (SH), 1111 (SW)
  - 8-bit lane mask M = m << off
  - 64-bit data D = zero-extended data << (8*off)
- States IDLE, BEAT0, BEAT1, RESP:
  - IDLE -> RESP if funct3 is illegal, or if M[7:4]!=0 and ALLOW_MISALIGNED=0. In RESP, st_err pulses for one cycle, then the state returns to IDLE. No mem_req is issued.
  - IDLE -> BEAT0 otherwise. BEAT0 drives mem_req=1, mem_addr={addr[31:2],00}, mem_be=M[3:0], mem_wdata=D[31:0].
  - BEAT0 holds while mem_req && !mem_gnt. All mem_* outputs stay stable while waiting.
  - BEAT0 on gnt: -> BEAT1 if M[7:4]!=0, else -> RESP with st_done pulse.
  - BEAT1 drives mem_addr = previous word address + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), mem_be=M[7:4], mem_wdata=D[63:32]. It holds until gnt, then -> RESP with st_done pulse.
  - RESP: exactly one of st_done/st_err is 1 for one cycle; mem_req=0; next state IDLE.
- Latency, aligned store with immediate gnt: accepted at cycle 0, mem_req at cycle 1, st_done at cycle 2, st_ready high again at cycle 3.
- Latency, split store with immediate gnts: st_done at cycle 3.
- st_ready=0 in every state except IDLE. A new st_valid is ignored until IDLE.
- mem_req never drops without a grant, except under rst.
- mem_gnt while mem_req=0 is ignored.
- SB never splits. SH splits only when off=3. SW splits when off!=0.

Decomposition:
- Shared package riscv_pkg:
  - funct3 constants F3_SB/F3_SH/F3_SW
  - st_state_t enum {IDLE, BEAT0, BEAT1, RESP}
  - size-mask function
- One combinational sub-module, st_lane_gen: (funct3, off, data) -> (M[7:0], D[63:0], illegal). The FSM and registers stay in store_lane_packer.

Test Plan:
- SB addr=0x1003, data=0xDEADBEEF, gnt tied 1 -> one beat: addr 0x1000, be=1000, wdata=0xEF000000; st_done at cycle 2.
- SW addr=0x2001, data=0x11223344, gnt 1 -> beat0: 0x2000, be=1110, wdata=0x22334400; beat1: 0x2004, be=0001, wdata=0x00000011; st_done once, at cycle 3.
- SH addr=0x0002, data=0xABCD, gnt held low 3 cycles -> mem_req/addr 0x0000/be 1100/wdata 0xABCD0000 stable for 4 cycles; st_done 1 cycle after gnt.
- funct3=011, or ALLOW_MISALIGNED=0 with SW addr=0x3002 -> no mem_req, st_err pulse at cycle 1, st_ready high at cycle 2.
- SW addr=0xFFFFFFFE, then rst asserted while in BEAT1 -> beat0 at 0xFFFFFFFC be=1100; beat1 address 0x00000000 be=0011. After the rst edge: mem_req=0, no st_done, st_ready=1 after rst falls.
